// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requester handshakes, register-file write port
// and pending-write lookup signals shared by the arbiter and its users.
interface regfile_wb_arbiter_if;
    logic        r0_valid, r0_ready, r1_valid, r1_ready;
    logic [4:0]  r0_addr, r1_addr;
    logic [31:0] r0_data, r1_data;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  chk_addr1, chk_addr2;
    logic        chk_hit1, chk_hit2, idle;
    modport master (
        output r0_valid, r0_addr, r0_data, r1_valid, r1_addr, r1_data, chk_addr1, chk_addr2,
        input  r0_ready, r1_ready, we, waddr, wdata, chk_hit1, chk_hit2, idle
    );
    modport slave (
        input  r0_valid, r0_addr, r0_data, r1_valid, r1_addr, r1_data, chk_addr1, chk_addr2,
        output r0_ready, r1_ready, we, waddr, wdata, chk_hit1, chk_hit2, idle
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two writeback FIFOs arbitrated onto one registered register-file write port.
// WB_FIXED_PRIO_EN selects fixed r0 priority instead of round-robin.
module regfile_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input logic clk,
    input logic rst,
    regfile_wb_arbiter_if.slave bus
);
    logic [1:0]       valid, ready, push, pop, ne, hit1, hit2;
    logic [1:0][36:0] din, head;
    logic             sel;
    assign valid      = {bus.r1_valid, bus.r0_valid};
    assign din[0]     = {bus.r0_addr, bus.r0_data};
    assign din[1]     = {bus.r1_addr, bus.r1_data};
    assign bus.r0_ready = ready[0];
    assign bus.r1_ready = ready[1];
    for (genvar i = 0; i < 2; i++) begin : g_fifo
        logic [36:0]      mem [DEPTH];
        logic [PTR_W-1:0] wp, rp, off;
        logic [PTR_W:0]   cnt;
        logic             h1, h2;
        assign ready[i] = !cnt[PTR_W];
        assign ne[i]    = cnt != '0;
        // x0 writes are accepted but never stored
        assign push[i]  = valid[i] && ready[i] && din[i][36:32] != 5'd0;
        assign head[i]  = mem[rp];
        assign hit1[i]  = h1;
        assign hit2[i]  = h2;
        always_ff @(posedge clk)
            if (push[i]) mem[wp] <= din[i];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                wp  <= '0;
                rp  <= '0;
            end else begin
                if (push[i]) wp <= wp + PTR_W'(1);
                if (pop[i]) rp <= rp + PTR_W'(1);
                cnt <= cnt + (PTR_W+1)'(push[i]) - (PTR_W+1)'(pop[i]);
            end
        end
        always_comb begin
            h1  = 1'b0;
            h2  = 1'b0;
            off = '0;
            for (int k = 0; k < DEPTH; k++) begin
                off = PTR_W'(k) - rp;
                if ({1'b0, off} < cnt) begin
                    h1 = h1 | (mem[k][36:32] == bus.chk_addr1);
                    h2 = h2 | (mem[k][36:32] == bus.chk_addr2);
                end
            end
        end
    end
`ifdef WB_FIXED_PRIO_EN
    assign sel = !ne[0];
`else
    logic rr_last;
    assign sel = (&ne) ? !rr_last : ne[1];
    always_ff @(posedge clk or posedge rst)
        if (rst) rr_last <= 1'b1;
        else if (|ne) rr_last <= sel;
`endif
    assign pop = (|ne) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.we    <= 1'b0;
            bus.waddr <= 5'd0;
            bus.wdata <= 32'd0;
        end else begin
            bus.we <= |ne;
            if (|ne) {bus.waddr, bus.wdata} <= head[sel];
        end
    end
    // the in-flight write is excluded: the register file forwards it
    assign bus.chk_hit1 = bus.chk_addr1 != 5'd0 && |hit1;
    assign bus.chk_hit2 = bus.chk_addr2 != 5'd0 && |hit2;
    assign bus.idle     = !ne[0] && !ne[1] && !bus.we;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random traffic checked against a queue-based model.
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    regfile_wb_arbiter_if bus();
    regfile_wb_arbiter #(.DEPTH(DEPTH), .PTR_W(1)) dut (.clk(clk), .rst(rst), .bus(bus));
    int compared = 0;
    int mismatched = 0;
    logic [36:0] q0[$], q1[$];
    logic        m_we, m_rr;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [31:0] seq_first;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic logic hit(input logic [4:0] a);
        hit = 1'b0;
        if (a != 5'd0) begin
            foreach (q0[k]) if (q0[k][36:32] == a) hit = 1'b1;
            foreach (q1[k]) if (q1[k][36:32] == a) hit = 1'b1;
        end
    endfunction
    task automatic check_all();
        chk("r0_ready", bus.r0_ready, q0.size() < DEPTH);
        chk("r1_ready", bus.r1_ready, q1.size() < DEPTH);
        chk("chk_hit1", bus.chk_hit1, hit(bus.chk_addr1));
        chk("chk_hit2", bus.chk_hit2, hit(bus.chk_addr2));
        chk("idle", bus.idle, q0.size() == 0 && q1.size() == 0 && !m_we);
        chk("we", bus.we, m_we);
        chk("waddr", bus.waddr, m_waddr);
        chk("wdata", bus.wdata, m_wdata);
    endtask
    task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] c1, input logic [4:0] c2);
        logic acc0, acc1, g;
        @(negedge clk);
        bus.r0_valid = v0; bus.r0_addr = a0; bus.r0_data = d0;
        bus.r1_valid = v1; bus.r1_addr = a1; bus.r1_data = d1;
        bus.chk_addr1 = c1; bus.chk_addr2 = c2;
        #1 check_all();
        acc0 = v0 && q0.size() < DEPTH;
        acc1 = v1 && q1.size() < DEPTH;
        @(posedge clk);
        if (q0.size() > 0 || q1.size() > 0) begin
`ifdef WB_FIXED_PRIO_EN
            g = q0.size() == 0;
`else
            g = (q0.size() > 0 && q1.size() > 0) ? !m_rr : q1.size() > 0;
`endif
            {m_waddr, m_wdata} = g ? q1.pop_front() : q0.pop_front();
            m_we = 1'b1;
            m_rr = g;
        end else
            m_we = 1'b0;
        if (acc0 && a0 != 5'd0) q0.push_back({a0, d0});
        if (acc1 && a1 != 5'd0) q1.push_back({a1, d1});
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
        bus.chk_addr1 = 5'd0; bus.chk_addr2 = 5'd0;
        q0.delete(); q1.delete();
        m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0; m_rr = 1'b1;
        #1;
        chk("rst_we", bus.we, 1'b0);
        chk("rst_waddr", bus.waddr, 5'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        chk("rst_r0_ready", bus.r0_ready, 1'b1);
        chk("rst_r1_ready", bus.r1_ready, 1'b1);
        chk("rst_idle", bus.idle, 1'b1);
        chk("rst_hit1", bus.chk_hit1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        bus.r0_valid = 1'b0; bus.r0_addr = 5'd0; bus.r0_data = 32'd0;
        bus.r1_valid = 1'b0; bus.r1_addr = 5'd0; bus.r1_data = 32'd0;
        bus.chk_addr1 = 5'd0; bus.chk_addr2 = 5'd0;
        do_reset();
        // single write: accepted at edge N, visible after edge N+1 for one cycle
        step(1, 5'd5, 32'h0000_1234, 0, 0, 0, 5'd5, 0);
        step(0, 0, 0, 0, 0, 0, 5'd5, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("single_we", bus.we, 1'b1);
        chk("single_waddr", bus.waddr, 5'd5);
        chk("single_wdata", bus.wdata, 32'h0000_1234);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("single_idle", bus.idle, 1'b1);
        // zero register is swallowed
        step(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("zero_no_we", bus.we, 1'b0);
        chk("zero_idle", bus.idle, 1'b1);
        // contention: both push every cycle; full FIFOs exercise ready drop
        for (int i = 0; i < 10; i++)
            step(1, 5'(2*i+1), 32'(100+i), 1, 5'(2*i+2), 32'(200+i), 5'(i%6), 0);
        seq_first = {27'd0, bus.waddr};
        step(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef WB_FIXED_PRIO_EN
        chk("contend_order", {31'd0, bus.waddr[0]}, {31'd0, seq_first[0]});
`else
        chk("contend_alt", {31'd0, bus.waddr[0]}, {31'd0, ~seq_first[0]});
`endif
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        // hazard lookup: r1 queues addr 7 while r0 saturates the port
        for (int i = 0; i < 8; i++)
            step(1, 5'(9+i), 32'(300+i), i == 1, 5'd7, 32'h77, 5'd7, 5'd0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 5'd7, 5'd0);
        // random traffic with mid-traffic resets
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 150; i++)
                step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
                     $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom,
                     5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)));
            do_reset();
            step(0, 0, 0, 0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0, 0, 0);
            chk("post_rst_no_stale", bus.we, 1'b0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
